// File: rtl/data_ram_responder_pkg.sv
// data_ram_responder_pkg
//   Shared bus widths, MMIO register map and STATUS bit positions for the
//   data-RAM responder. Software headers and the bench use the same offsets.
package data_ram_responder_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int SEL_W  = 4;      // byte-lane strobes

    // MMIO byte offsets inside the 32-byte window
    localparam logic [31:0] MMIO_OFF_CYCLE_LO  = 32'h00;
    localparam logic [31:0] MMIO_OFF_CYCLE_HI  = 32'h04;
    localparam logic [31:0] MMIO_OFF_TIMER_CMP = 32'h08;
    localparam logic [31:0] MMIO_OFF_STATUS    = 32'h0C;
    localparam logic [31:0] MMIO_OFF_SCRATCH   = 32'h10;

    // Word indices used by the decoder (addr[4:2])
    localparam logic [2:0] IDX_CYCLE_LO  = MMIO_OFF_CYCLE_LO[4:2];
    localparam logic [2:0] IDX_CYCLE_HI  = MMIO_OFF_CYCLE_HI[4:2];
    localparam logic [2:0] IDX_TIMER_CMP = MMIO_OFF_TIMER_CMP[4:2];
    localparam logic [2:0] IDX_STATUS    = MMIO_OFF_STATUS[4:2];
    localparam logic [2:0] IDX_SCRATCH   = MMIO_OFF_SCRATCH[4:2];

    localparam int STATUS_MATCH_BIT  = 0;
    localparam int STATUS_IRQ_EN_BIT = 1;

    // Which source drives the held read-data output
    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_RAM  = 2'd1,
        SRC_MMIO = 2'd2
    } rd_src_e;

    typedef struct packed {
        logic              en;
        logic [SEL_W-1:0]  we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

    // Merge strobed byte lanes of wdata into cur
    function automatic logic [DATA_W-1:0] apply_strobe(
        input logic [DATA_W-1:0] cur,
        input logic [DATA_W-1:0] wdata,
        input logic [SEL_W-1:0]  strb
    );
        logic [DATA_W-1:0] r;
        r = cur;
        for (int i = 0; i < SEL_W; i++)
            if (strb[i]) r[8*i +: 8] = wdata[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/data_ram_responder_ram_byte_array.sv
// ram_byte_array
//   Single-port synchronous word RAM with per-byte write strobes and a
//   1-cycle registered read. No reset on contents or read register, so the
//   array maps onto block RAM; swap this file for a vendor macro if needed.
//   Read data only updates on a read (en=1, we=0) and holds otherwise.
// Ports
//   clk    clock
//   en     access enable
//   we     byte-lane write strobes, 0 = read
//   addr   word address
//   wdata  write data, lane i = bits [8i+7:8i]
//   rdata  registered read data
module ram_byte_array #(
    parameter int ADDR_W    = 12,
    parameter int NUM_LANES = 4
) (
    input  logic                   clk,
    input  logic                   en,
    input  logic [NUM_LANES-1:0]   we,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [NUM_LANES*8-1:0] wdata,
    output logic [NUM_LANES*8-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic rd_en;
    assign rd_en = en && (we == '0);

    // One independent byte-wide array per lane keeps each lane a plain
    // single-writer memory.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] dout;

        always_ff @(posedge clk) begin
            if (en && we[g]) mem[addr] <= wdata[8*g +: 8];
            if (rd_en)       dout      <= mem[addr];
        end

        assign rdata[8*g +: 8] = dout;
    end

endmodule

// File: rtl/data_ram_responder.sv
// data_ram_responder
//   Target end of the core's data-RAM port. Decodes each access to on-chip
//   RAM, a 32-byte MMIO window (cycle counter, compare timer, status,
//   scratch) or unmapped space. Read data is registered and held until the
//   next read; unmapped accesses read 0 and pulse bus_err.
// Ports
//   clk             clock
//   rst             asynchronous reset, active-high
//   ram_en          access request this cycle
//   ram_write_en    byte-lane write strobes, 0 = read
//   ram_addr        byte address, [1:0] ignored
//   ram_write_data  write data
//   ram_read_data   read data, valid the cycle after a read
//   timer_irq       STATUS.match & STATUS.irq_en
//   bus_err         1-cycle pulse after an unmapped access
module data_ram_responder
    import data_ram_responder_pkg::*;
#(
    parameter int          RAM_DEPTH_LOG2 = 12,
    parameter logic [31:0] MMIO_BASE      = 32'h1000_0000,
    parameter logic [31:0] CMP_RESET      = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_en,
    input  logic [3:0]  ram_write_en,
    input  logic [31:0] ram_addr,
    input  logic [31:0] ram_write_data,
    output logic [31:0] ram_read_data,
    output logic        timer_irq,
    output logic        bus_err
);

    bus_req_t req;
    assign req = '{en: ram_en, we: ram_write_en, addr: ram_addr, wdata: ram_write_data};

    // Byte offset bits within a word carry no meaning on this port
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^req.addr[1:0];

    // ---------------- decode ----------------
    logic       rd_req, wr_req;
    logic       ram_hit, mmio_hit;
    logic [2:0] reg_idx;

    assign rd_req   = req.en && (req.we == '0);
    assign wr_req   = req.en && (req.we != '0);
    assign ram_hit  = (req.addr[ADDR_W-1:RAM_DEPTH_LOG2+2] == '0);
    assign mmio_hit = !ram_hit && (req.addr[ADDR_W-1:5] == MMIO_BASE[ADDR_W-1:5]);
    assign reg_idx  = req.addr[4:2];

    logic mmio_rd, mmio_wr;
    assign mmio_rd = rd_req && mmio_hit;
    assign mmio_wr = wr_req && mmio_hit;

    // ---------------- RAM ----------------
    logic [DATA_W-1:0] ram_dout;

    ram_byte_array #(
        .ADDR_W    (RAM_DEPTH_LOG2),
        .NUM_LANES (SEL_W)
    ) u_ram (
        .clk   (clk),
        .en    (req.en && ram_hit),
        .we    (req.we),
        .addr  (req.addr[RAM_DEPTH_LOG2+1:2]),
        .wdata (req.wdata),
        .rdata (ram_dout)
    );

    // ---------------- MMIO registers ----------------
    logic [63:0]       cycle_cnt;
    logic [31:0]       hi_snap;
    logic [31:0]       timer_cmp;
    logic              st_match;
    logic              st_irq_en;
    logic [31:0]       scratch;

    logic cmp_hit, w1c_match;
    assign cmp_hit   = (cycle_cnt[31:0] == timer_cmp);
    assign w1c_match = mmio_wr && (reg_idx == IDX_STATUS) &&
                       req.we[0] && req.wdata[STATUS_MATCH_BIT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cycle_cnt <= '0;
        else     cycle_cnt <= cycle_cnt + 64'd1;
    end

    // Snapshot the upper half at a CYCLE_LO read so a LO-then-HI pair is coherent
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                    hi_snap <= '0;
        else if (mmio_rd && reg_idx == IDX_CYCLE_LO) hi_snap <= cycle_cnt[63:32];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_cmp <= CMP_RESET;
            scratch   <= '0;
            st_irq_en <= 1'b0;
        end else if (mmio_wr) begin
            if (reg_idx == IDX_TIMER_CMP) timer_cmp <= apply_strobe(timer_cmp, req.wdata, req.we);
            if (reg_idx == IDX_SCRATCH)   scratch   <= apply_strobe(scratch, req.wdata, req.we);
            if (reg_idx == IDX_STATUS && req.we[0])
                st_irq_en <= req.wdata[STATUS_IRQ_EN_BIT];
        end
    end

    // A compare hit in the same cycle as a W1C keeps the flag set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) st_match <= 1'b0;
        else     st_match <= cmp_hit || (st_match && !w1c_match);
    end

    assign timer_irq = st_match && st_irq_en;

    // ---------------- read path ----------------
    logic [31:0] mmio_rd_val;

    always_comb begin
        mmio_rd_val = '0;
        case (reg_idx)
            IDX_CYCLE_LO:  mmio_rd_val = cycle_cnt[31:0];
            IDX_CYCLE_HI:  mmio_rd_val = hi_snap;
            IDX_TIMER_CMP: mmio_rd_val = timer_cmp;
            IDX_STATUS: begin
                mmio_rd_val[STATUS_MATCH_BIT]  = st_match;
                mmio_rd_val[STATUS_IRQ_EN_BIT] = st_irq_en;
            end
            IDX_SCRATCH:   mmio_rd_val = scratch;
            default:       mmio_rd_val = '0;
        endcase
    end

    rd_src_e     rd_src;
    logic [31:0] mmio_rdata;

    // Source select only moves on reads, so writes and idle cycles hold the output.
    // RAM data is held by the array's own read register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_src     <= SRC_ZERO;
            mmio_rdata <= '0;
        end else if (rd_req) begin
            if (ram_hit)       rd_src <= SRC_RAM;
            else if (mmio_hit) rd_src <= SRC_MMIO;
            else               rd_src <= SRC_ZERO;
            if (mmio_hit) mmio_rdata <= mmio_rd_val;
        end
    end

    always_comb begin
        ram_read_data = '0;
        case (rd_src)
            SRC_RAM:  ram_read_data = ram_dout;
            SRC_MMIO: ram_read_data = mmio_rdata;
            default:  ram_read_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus_err <= 1'b0;
        else     bus_err <= req.en && !ram_hit && !mmio_hit;
    end

endmodule

// File: tb/tb_data_ram_responder.sv
module tb_data_ram_responder;
    import data_ram_responder_pkg::*;

    localparam logic [31:0] MMIO = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ram_en = 1'b0;
    logic [3:0]  ram_write_en = 4'h0;
    logic [31:0] ram_addr = 32'h0;
    logic [31:0] ram_write_data = 32'h0;
    logic [31:0] ram_read_data;
    logic        timer_irq;
    logic        bus_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    // Reference cycle count: cycles since reset deassertion
    logic [63:0] tb_cyc;

    data_ram_responder dut (
        .clk            (clk),
        .rst            (rst),
        .ram_en         (ram_en),
        .ram_write_en   (ram_write_en),
        .ram_addr       (ram_addr),
        .ram_write_data (ram_write_data),
        .ram_read_data  (ram_read_data),
        .timer_irq      (timer_irq),
        .bus_err        (bus_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) tb_cyc <= 64'd0;
        else     tb_cyc <= tb_cyc + 64'd1;
    end

    task automatic set_bus(input logic en, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
        ram_en = en; ram_write_en = we; ram_addr = a; ram_write_data = d;
    endtask

    task automatic drive(input logic en, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        set_bus(en, we, a, d);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
        drive(1'b1, 4'h0, a, 32'h0);
        sb.push_back('{name: nm, val: exp});
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #2;
        checks++; if (ram_read_data !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", ram_read_data); end
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b want 0", timer_irq); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL rst_bus_err: got %b want 0", bus_err); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        set_bus(1'b1, 4'h0, MMIO + MMIO_OFF_CYCLE_LO, 32'h0);
        sb.push_back('{name: "cycle_lo_after_rst", val: tb_cyc[31:0]});
        rd(MMIO + MMIO_OFF_CYCLE_HI, 32'h0, "cycle_hi_after_rst");
        e = sb.pop_front(); checks++; if (ram_read_data !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, ram_read_data, e.val); end
        rd(MMIO + MMIO_OFF_TIMER_CMP, 32'hFFFF_FFFF, "cmp_rst");
        e = sb.pop_front(); checks++; if (ram_read_data !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, ram_read_data, e.val); end
        rd(MMIO + MMIO_OFF_STATUS, 32'h0, "status_rst");
        e = sb.pop_front(); checks++; if (ram_read_data !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, ram_read_data, e.val); end
        rd(MMIO + MMIO_OFF_SCRATCH, 32'h0, "scratch_rst");
        e = sb.pop_front(); checks++; if (ram_read_data !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, ram_read_data, e.val); end
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        e = sb.pop_front(); checks++; if (ram_read_data !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, ram_read_data, e.val); end
    endtask

    task automatic test_byte_write;
        drive(1'b1, 4'hF, 32'h40, 32'hDEAD_BEEF);
        drive(1'b1, 4'b0010, 32'h40, 32'h0000_5500);
        rd(32'h40, 32'hDEAD_55EF, "ram_lane1_write");
        drive(1'b1, 4'hF, MMIO + MMIO_OFF_SCRATCH, 32'h1122_3344);
        e = sb.pop_front(); checks++; if (ram_read_data !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, ram_read_data, e.val); end
        drive(1'b1, 4'b1000, MMIO + MMIO_OFF_SCRATCH, 32'hAA00_0000);
        rd(MMIO + MMIO_OFF_SCRATCH, 32'hAA22_3344, "scratch_lane3_write");
        drive(1'b1, 4'hF, MMIO + 32'h14, 32'hFFFF_FFFF);
        e = sb.pop_front(); checks++; if (ram_read_data !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, ram_read_data, e.val); end
        drive(1'b1, 4'hF, MMIO + MMIO_OFF_CYCLE_HI, 32'h1234_5678);
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reserved_no_bus_err: got %b want 0", bus_err); end
        rd(MMIO + 32'h14, 32'h0, "reserved_reads_zero");
        rd(MMIO + MMIO_OFF_CYCLE_HI, 32'h0, "cycle_hi_ro");
        e = sb.pop_front(); checks++; if (ram_read_data !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, ram_read_data, e.val); end
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        e = sb.pop_front(); checks++; if (ram_read_data !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, ram_read_data, e.val); end
    endtask

    task automatic test_back_to_back;
        drive(1'b1, 4'hF, 32'h80, 32'h1234_5678);
        rd(32'h80, 32'h1234_5678, "wr_then_rd");
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        e = sb.pop_front(); checks++; if (ram_read_data !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, ram_read_data, e.val); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'h0, 32'h0, 32'h0);
            checks++; if (ram_read_data !== 32'h1234_5678) begin errors++; $display("FAIL hold_idle%0d: got %h want 12345678", i, ram_read_data); end
        end
        drive(1'b1, 4'hF, 32'h84, 32'h0BAD_0BAD);
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        checks++; if (ram_read_data !== 32'h1234_5678) begin errors++; $display("FAIL hold_write: got %h want 12345678", ram_read_data); end
    endtask

    task automatic test_timer;
        logic [31:0] cmp;
        int n;
        @(negedge clk);
        cmp = tb_cyc[31:0] + 32'd10;
        set_bus(1'b1, 4'hF, MMIO + MMIO_OFF_TIMER_CMP, cmp);
        drive(1'b1, 4'hF, MMIO + MMIO_OFF_STATUS, 32'h2);
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        n = 0;
        while (tb_cyc[31:0] != cmp && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            errors++; checks++; $display("FAIL irq_timeout: got cycle %0d want %0d", tb_cyc[31:0], cmp);
        end else begin
            checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL irq_early: got %b want 0", timer_irq); end
            @(negedge clk);
            checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b want 1", timer_irq); end
        end
        drive(1'b1, 4'hF, MMIO + MMIO_OFF_STATUS, 32'h3);
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL irq_w1c: got %b want 0", timer_irq); end
        // W1C lands on the same edge as a fresh compare hit
        @(negedge clk);
        cmp = tb_cyc[31:0] + 32'd2;
        set_bus(1'b1, 4'hF, MMIO + MMIO_OFF_TIMER_CMP, cmp);
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        drive(1'b1, 4'hF, MMIO + MMIO_OFF_STATUS, 32'h3);
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL match_vs_w1c: got %b want 1", timer_irq); end
        rd(MMIO + MMIO_OFF_STATUS, 32'h3, "status_after_coincident");
        drive(1'b1, 4'hF, MMIO + MMIO_OFF_STATUS, 32'h1);
        e = sb.pop_front(); checks++; if (ram_read_data !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, ram_read_data, e.val); end
        drive(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic test_snapshot;
        @(negedge clk);
        force dut.cycle_cnt = 64'h0000_0005_FFFF_FFFF;
        set_bus(1'b1, 4'h0, MMIO + MMIO_OFF_CYCLE_LO, 32'h0);
        sb.push_back('{name: "cycle_lo_forced", val: 32'hFFFF_FFFF});
        @(posedge clk);
        #1 release dut.cycle_cnt;
        rd(MMIO + MMIO_OFF_CYCLE_HI, 32'h0000_0005, "cycle_hi_snapshot");
        e = sb.pop_front(); checks++; if (ram_read_data !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, ram_read_data, e.val); end
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        e = sb.pop_front(); checks++; if (ram_read_data !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, ram_read_data, e.val); end
    endtask

    task automatic test_unmapped;
        drive(1'b1, 4'hF, 32'h0, 32'hCAFE_F00D);
        drive(1'b1, 4'hF, 32'h2000_0000, 32'h1111_1111);
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL bus_err_wr: got %b want 1", bus_err); end
        rd(32'h2000_0000, 32'h0, "unmapped_read");
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL bus_err_pulse: got %b want 0", bus_err); end
        rd(32'h0, 32'hCAFE_F00D, "ram_untouched");
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL bus_err_rd: got %b want 1", bus_err); end
        e = sb.pop_front(); checks++; if (ram_read_data !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, ram_read_data, e.val); end
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        e = sb.pop_front(); checks++; if (ram_read_data !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, ram_read_data, e.val); end
        // Reset in the middle of a read: output drops immediately
        rd(32'h40, 32'hDEAD_55EF, "pre_reset_read");
        @(posedge clk);
        #2;
        e = sb.pop_front(); checks++; if (ram_read_data !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, ram_read_data, e.val); end
        rst = 1'b1;
        #1;
        checks++; if (ram_read_data !== 32'h0) begin errors++; $display("FAIL rst_mid_read: got %h want 0", ram_read_data); end
        set_bus(1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        rd(32'h40, 32'hDEAD_55EF, "ram_kept_over_reset");
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        e = sb.pop_front(); checks++; if (ram_read_data !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.name, ram_read_data, e.val); end
    endtask

    initial begin
        test_reset;
        test_byte_write;
        test_back_to_back;
        test_timer;
        test_snapshot;
        test_unmapped;
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
